// File: rtl/conv2d_layer_sequencer.sv
// conv2d_layer_sequencer
// Walks a 3x3-padded convolution layer: for every output channel it loops over
// all input channels, fetching one kernel per pass and streaming height rows of
// width+2 columns into the PE, then drains the PE before the next output channel.
// All control outputs are registered; pulses are one clock wide.
`timescale 1ns/1ps

module conv2d_layer_sequencer #(
    parameter int DIM_WIDTH = 8,
    parameter int CH_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic [DIM_WIDTH-1:0] cfg_width,
    input  logic [DIM_WIDTH-1:0] cfg_height,
    input  logic [CH_WIDTH-1:0]  cfg_in_ch,
    input  logic [CH_WIDTH-1:0]  cfg_out_ch,
    output logic                 kernel_req,
    input  logic                 kernel_ack,
    input  logic                 PE_ready,
    input  logic                 PE_with_buffers_IDLE,
    output logic                 PE_Reset,
    output logic                 Load_kernel_reg,
    output logic                 Stream_mid_row,
    output logic                 Stream_last_row,
    output logic                 Output_valid,
    output logic                 Done_1row,
    output logic                 last_channel,
    output logic [7:0]           b_counter_output,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_error
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LOAD_KERNEL = 3'd1,
        WAIT_READY  = 3'd2,
        STREAM      = 3'd3,
        ROW_END     = 3'd4,
        DRAIN       = 3'd5,
        DONE        = 3'd6
    } state_t;

    localparam logic [DIM_WIDTH:0]   COL_ONE = {{DIM_WIDTH{1'b0}}, 1'b1};
    localparam logic [DIM_WIDTH:0]   COL_TWO = {{(DIM_WIDTH-1){1'b0}}, 2'b10};
    localparam logic [DIM_WIDTH-1:0] DIM_ONE = {{(DIM_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CH_WIDTH-1:0]  CH_ONE  = {{(CH_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_r;
    // Latched job geometry, stored as "last index" values so the counters
    // compare for equality and never need to wrap.
    logic [DIM_WIDTH:0]   col_last_r;   // width + 1 (extra bit: width=max still fits)
    logic [DIM_WIDTH-1:0] row_last_r;   // height - 1
    logic [CH_WIDTH-1:0]  in_last_r;    // in_ch - 1
    logic [CH_WIDTH-1:0]  out_last_r;   // out_ch - 1
    logic [DIM_WIDTH:0]   col_r;
    logic [DIM_WIDTH-1:0] row_r;
    logic [CH_WIDTH-1:0]  in_ch_r;
    logic [CH_WIDTH-1:0]  out_ch_r;

    logic                 cfg_ok_s;

    // A job is only accepted when every dimension is nonzero.
    always_comb begin
        cfg_ok_s = (cfg_width != '0) && (cfg_height != '0) &&
                   (cfg_in_ch != '0) && (cfg_out_ch != '0);
    end

    // Sequencer FSM with all PE control outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_r          <= IDLE;
            col_last_r       <= '0;
            row_last_r       <= '0;
            in_last_r        <= '0;
            out_last_r       <= '0;
            col_r            <= '0;
            row_r            <= '0;
            in_ch_r          <= '0;
            out_ch_r         <= '0;
            kernel_req       <= 1'b0;
            PE_Reset         <= 1'b0;
            Load_kernel_reg  <= 1'b0;
            Stream_mid_row   <= 1'b0;
            Stream_last_row  <= 1'b0;
            Output_valid     <= 1'b0;
            Done_1row        <= 1'b0;
            last_channel     <= 1'b0;
            b_counter_output <= 8'h00;
            busy             <= 1'b0;
            done             <= 1'b0;
            cfg_error        <= 1'b0;
        end else begin
            // Single-cycle strobes fall back to zero unless a state raises them.
            PE_Reset        <= 1'b0;
            Load_kernel_reg <= 1'b0;
            Stream_mid_row  <= 1'b0;
            Stream_last_row <= 1'b0;
            Output_valid    <= 1'b0;
            Done_1row       <= 1'b0;
            done            <= 1'b0;
            cfg_error       <= 1'b0;

            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok_s) begin
                            col_last_r       <= {1'b0, cfg_width} + COL_ONE;
                            row_last_r       <= cfg_height - DIM_ONE;
                            in_last_r        <= cfg_in_ch - CH_ONE;
                            out_last_r       <= cfg_out_ch - CH_ONE;
                            col_r            <= '0;
                            row_r            <= '0;
                            in_ch_r          <= '0;
                            out_ch_r         <= '0;
                            b_counter_output <= 8'h00;
                            PE_Reset         <= 1'b1;
                            kernel_req       <= 1'b1;
                            busy             <= 1'b1;
                            last_channel     <= (cfg_in_ch == CH_ONE);
                            state_r          <= LOAD_KERNEL;
                        end else begin
                            cfg_error <= 1'b1;
                        end
                    end
                end

                LOAD_KERNEL: begin
                    // kernel_req stays high until the loader acknowledges.
                    if (kernel_ack) begin
                        kernel_req      <= 1'b0;
                        Load_kernel_reg <= 1'b1;
                        state_r         <= WAIT_READY;
                    end
                end

                WAIT_READY: begin
                    if (PE_ready) begin
                        state_r <= STREAM;
                    end
                end

                STREAM: begin
                    // A beat is consumed only while the PE is ready; otherwise col holds.
                    if (PE_ready) begin
                        Stream_mid_row  <= (row_r != row_last_r);
                        Stream_last_row <= (row_r == row_last_r);
                        Output_valid    <= (col_r >= COL_TWO);
                        if (col_r == col_last_r) begin
                            col_r     <= '0;
                            Done_1row <= 1'b1;
                            state_r   <= ROW_END;
                        end else begin
                            col_r <= col_r + COL_ONE;
                        end
                    end
                end

                ROW_END: begin
                    if (row_r != row_last_r) begin
                        row_r   <= row_r + DIM_ONE;
                        state_r <= WAIT_READY;
                    end else begin
                        row_r <= '0;
                        if (in_ch_r != in_last_r) begin
                            in_ch_r      <= in_ch_r + CH_ONE;
                            last_channel <= ((in_ch_r + CH_ONE) == in_last_r);
                            kernel_req   <= 1'b1;
                            state_r      <= LOAD_KERNEL;
                        end else begin
                            state_r <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    // The PE must empty its buffers before the bias index moves on.
                    if (PE_with_buffers_IDLE) begin
                        if (out_ch_r != out_last_r) begin
                            out_ch_r         <= out_ch_r + CH_ONE;
                            b_counter_output <= 8'(out_ch_r + CH_ONE);
                            in_ch_r          <= '0;
                            last_channel     <= (in_last_r == '0);
                            kernel_req       <= 1'b1;
                            state_r          <= LOAD_KERNEL;
                        end else begin
                            done    <= 1'b1;
                            state_r <= DONE;
                        end
                    end
                end

                DONE: begin
                    busy         <= 1'b0;
                    last_channel <= 1'b0;
                    state_r      <= IDLE;
                end

                default: begin
                    kernel_req   <= 1'b0;
                    busy         <= 1'b0;
                    last_channel <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_layer_sequencer.sv
// Directed self-checking bench for conv2d_layer_sequencer. A single process
// advances the clock one cycle at a time, samples outputs on the falling edge,
// accumulates event counts, and models the kernel loader (ack 2 cycles after req).
`timescale 1ns/1ps

module tb_conv2d_layer_sequencer;

    logic       clk;
    logic       Reset;
    logic       start;
    logic [7:0] cfg_width;
    logic [7:0] cfg_height;
    logic [7:0] cfg_in_ch;
    logic [7:0] cfg_out_ch;
    logic       kernel_req;
    logic       kernel_ack;
    logic       PE_ready;
    logic       PE_with_buffers_IDLE;
    logic       PE_Reset;
    logic       Load_kernel_reg;
    logic       Stream_mid_row;
    logic       Stream_last_row;
    logic       Output_valid;
    logic       Done_1row;
    logic       last_channel;
    logic [7:0] b_counter_output;
    logic       busy;
    logic       done;
    logic       cfg_error;

    conv2d_layer_sequencer #(.DIM_WIDTH(8), .CH_WIDTH(8)) dut (
        .clk                  (clk),
        .Reset                (Reset),
        .start                (start),
        .cfg_width            (cfg_width),
        .cfg_height           (cfg_height),
        .cfg_in_ch            (cfg_in_ch),
        .cfg_out_ch           (cfg_out_ch),
        .kernel_req           (kernel_req),
        .kernel_ack           (kernel_ack),
        .PE_ready             (PE_ready),
        .PE_with_buffers_IDLE (PE_with_buffers_IDLE),
        .PE_Reset             (PE_Reset),
        .Load_kernel_reg      (Load_kernel_reg),
        .Stream_mid_row       (Stream_mid_row),
        .Stream_last_row      (Stream_last_row),
        .Output_valid         (Output_valid),
        .Done_1row            (Done_1row),
        .last_channel         (last_channel),
        .b_counter_output     (b_counter_output),
        .busy                 (busy),
        .done                 (done),
        .cfg_error            (cfg_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // event counters, cleared per scenario
    int cyc, n_stream, n_mid, n_last, n_both, n_valid, n_d1r, n_lk, n_pr;
    int n_done, n_cerr, n_busy, n_busy_nolc, n_lc_stream;
    int first_s, last_s, first_v, last_v;
    int kdly;
    bit ack_auto;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        cyc = 0; n_stream = 0; n_mid = 0; n_last = 0; n_both = 0; n_valid = 0;
        n_d1r = 0; n_lk = 0; n_pr = 0; n_done = 0; n_cerr = 0; n_busy = 0;
        n_busy_nolc = 0; n_lc_stream = 0;
        first_s = -1; last_s = -1; first_v = -1; last_v = -1;
    endtask

    // Advance one clock, sample outputs on the falling edge, run the loader model.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (Stream_mid_row || Stream_last_row) begin
            n_stream++;
            if (last_channel) n_lc_stream++;
            if (first_s < 0) first_s = cyc;
            last_s = cyc;
        end
        if (Output_valid) begin
            n_valid++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
        end
        if (Stream_mid_row)                    n_mid++;
        if (Stream_last_row)                   n_last++;
        if (Stream_mid_row && Stream_last_row) n_both++;
        if (Done_1row)                         n_d1r++;
        if (Load_kernel_reg)                   n_lk++;
        if (PE_Reset)                          n_pr++;
        if (done)                              n_done++;
        if (cfg_error)                         n_cerr++;
        if (busy)                              n_busy++;
        if (busy && !last_channel)             n_busy_nolc++;
        if (ack_auto) begin
            if (kernel_req && !kernel_ack) begin
                kdly++;
                if (kdly >= 2) kernel_ack = 1'b1;
            end else begin
                kdly = 0;
                kernel_ack = 1'b0;
            end
        end
    endtask

    task automatic kick(input int w, input int h, input int ci, input int co);
        cfg_width = 8'(w); cfg_height = 8'(h); cfg_in_ch = 8'(ci); cfg_out_ch = 8'(co);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            step();
            k++;
        end
        check_eq(tag, 32'(done), 32'd1);
    endtask

    function automatic logic [18:0] out_vec();
        return {kernel_req, PE_Reset, Load_kernel_reg, Stream_mid_row, Stream_last_row,
                Output_valid, Done_1row, last_channel, b_counter_output, busy, done, cfg_error};
    endfunction

    initial begin
        int k;
        Reset = 1'b1; start = 1'b0; cfg_width = 8'd0; cfg_height = 8'd0;
        cfg_in_ch = 8'd0; cfg_out_ch = 8'd0; kernel_ack = 1'b0; PE_ready = 1'b1;
        PE_with_buffers_IDLE = 1'b1; ack_auto = 1'b1; kdly = 0;
        clear_counts();

        // ---- reset state
        step(); step();
        check_eq("reset_outputs", 32'(out_vec()), 32'd0);
        Reset = 1'b0;
        step();

        // ---- job 1: W=4 H=3 Cin=2 Cout=1, cfg scrambled while busy
        clear_counts();
        kick(4, 3, 2, 1);
        cfg_width = 8'd9; cfg_height = 8'd0; cfg_in_ch = 8'd5; cfg_out_ch = 8'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        run_until_done("j1_done_reached", 400);
        step(); step(); step();
        check_eq("j1_stream_beats", n_stream, 36);
        check_eq("j1_mid_beats", n_mid, 24);
        check_eq("j1_last_beats", n_last, 12);
        check_eq("j1_mid_and_last", n_both, 0);
        check_eq("j1_valid", n_valid, 24);
        check_eq("j1_done_1row", n_d1r, 6);
        check_eq("j1_load_kernel", n_lk, 2);
        check_eq("j1_pe_reset", n_pr, 1);
        check_eq("j1_done_pulses", n_done, 1);
        check_eq("j1_lastch_beats", n_lc_stream, 18);
        check_eq("j1_busy_after", 32'(busy), 32'd0);

        // ---- job 2: W=2 H=2 Cin=1 Cout=3, DRAIN gated by PE_with_buffers_IDLE
        clear_counts();
        PE_with_buffers_IDLE = 1'b0;
        kick(2, 2, 1, 3);
        for (int oc = 0; oc < 3; oc++) begin
            k = 0;
            while (n_d1r < 2 * (oc + 1) && k < 200) begin
                step();
                k++;
            end
            check_eq("j2_pass_rows", n_d1r, 2 * (oc + 1));
            step(); step(); step(); step();
            check_eq("j2_drain_hold_bias", 32'(b_counter_output), 32'(oc));
            check_eq("j2_drain_hold_done", 32'(done), 32'd0);
            PE_with_buffers_IDLE = 1'b1;
            step();
            PE_with_buffers_IDLE = 1'b0;
            if (oc < 2) check_eq("j2_bias_step", 32'(b_counter_output), 32'(oc + 1));
            else        check_eq("j2_done", 32'(done), 32'd1);
        end
        PE_with_buffers_IDLE = 1'b1;
        step(); step();
        check_eq("j2_busy_seen", 32'(n_busy > 10), 32'd1);
        check_eq("j2_busy_without_lastch", n_busy_nolc, 0);
        check_eq("j2_load_kernel", n_lk, 3);
        check_eq("j2_valid", n_valid, 12);
        check_eq("j2_bias_final", 32'(b_counter_output), 32'd2);

        // ---- job 3: PE_ready dropped 3 cycles while col=3
        clear_counts();
        kick(4, 1, 1, 1);
        k = 0;
        while (n_stream < 1 && k < 50) begin
            step();
            k++;
        end
        check_eq("j3_first_beat", n_stream, 1);
        step(); step();
        PE_ready = 1'b0;
        step(); step(); step();
        PE_ready = 1'b1;
        run_until_done("j3_done_reached", 100);
        check_eq("j3_valid", n_valid, 4);
        check_eq("j3_stream_beats", n_stream, 6);
        check_eq("j3_stream_gap", last_s - first_s + 1 - n_stream, 3);
        check_eq("j3_valid_gap", last_v - first_v + 1 - n_valid, 3);
        step(); step();

        // ---- zero height rejected; stray ack in IDLE ignored
        clear_counts();
        kick(4, 0, 1, 1);
        step(); step(); step();
        check_eq("cfg_err_pulses", n_cerr, 1);
        check_eq("cfg_err_busy", n_busy, 0);
        check_eq("cfg_err_pe_reset", n_pr, 0);
        ack_auto = 1'b0;
        kernel_ack = 1'b1;
        step(); step();
        kernel_ack = 1'b0;
        ack_auto = 1'b1;
        step();
        check_eq("stray_ack_load", n_lk, 0);
        check_eq("stray_ack_busy", 32'(busy), 32'd0);

        // ---- reset in STREAM on row 1, then restart
        clear_counts();
        kick(4, 3, 1, 1);
        k = 0;
        while (n_stream < 8 && k < 100) begin
            step();
            k++;
        end
        check_eq("rst_reached_row1", n_d1r, 1);
        Reset = 1'b1;
        step();
        check_eq("rst_mid_outputs", 32'(out_vec()), 32'd0);
        Reset = 1'b0;
        step();
        check_eq("rst_stays_idle", 32'(busy), 32'd0);
        clear_counts();
        kick(4, 3, 1, 1);
        check_eq("rst_restart_pe_reset", n_pr, 1);
        check_eq("rst_restart_bias", 32'(b_counter_output), 32'd0);
        k = 0;
        while (n_stream < 1 && k < 50) begin
            step();
            k++;
        end
        check_eq("rst_restart_row0", n_mid, 1);
        run_until_done("rst_restart_done", 200);
        check_eq("rst_restart_rows", n_d1r, 3);
        check_eq("rst_restart_beats", n_stream, 18);
        step(); step();

        // ---- start held high: W=1 H=1 gives 3 beats, 1 valid, one job only
        clear_counts();
        cfg_width = 8'd1; cfg_height = 8'd1; cfg_in_ch = 8'd1; cfg_out_ch = 8'd1;
        start = 1'b1;
        run_until_done("hold_done_reached", 100);
        start = 1'b0;
        step(); step(); step();
        check_eq("hold_pe_reset", n_pr, 1);
        check_eq("hold_done_pulses", n_done, 1);
        check_eq("w1_stream_beats", n_stream, 3);
        check_eq("w1_valid", n_valid, 1);
        check_eq("hold_idle_after", 32'(busy), 32'd0);

        // start kept high past done -> exactly one more job
        clear_counts();
        start = 1'b1;
        run_until_done("rehold_first_done", 100);
        step(); step();
        start = 1'b0;
        check_eq("rehold_busy_again", 32'(busy), 32'd1);
        step();
        run_until_done("rehold_second_done", 100);
        step(); step(); step();
        check_eq("rehold_pe_reset", n_pr, 2);
        check_eq("rehold_done_pulses", n_done, 2);
        check_eq("rehold_idle_after", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv2d_layer_sequencer.md
CONV2D_LAYER_SEQUENCER -- requirements
Module: conv2d_layer_sequencer

Interface
REQ-001 SHALL have parameter DIM_WIDTH, default 8, bit width of image width/height configuration and counters.
REQ-002 SHALL have parameter CH_WIDTH, default 8, bit width of channel configuration and counters.
REQ-003 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-004 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, job request; sampled only in IDLE.
REQ-006 SHALL have ports cfg_width and cfg_height, input, DIM_WIDTH each, output image columns and rows; latched on accepted start.
REQ-007 SHALL have ports cfg_in_ch and cfg_out_ch, input, CH_WIDTH each, input and output channel counts; latched on accepted start.
REQ-008 SHALL have ports kernel_req (output, 1) and kernel_ack (input, 1), the kernel fetch handshake to the kernel loader.
REQ-009 SHALL have ports PE_ready and PE_with_buffers_IDLE, input, 1 each, status from the PE.
REQ-010 SHALL have ports PE_Reset, Load_kernel_reg, Stream_mid_row, Stream_last_row, Output_valid, Done_1row and last_channel, output, 1 each, PE control.
REQ-011 SHALL have port b_counter_output, output, 8, current output-channel index for bias selection.
REQ-012 SHALL have ports busy (output, 1), done (output, 1 pulse) and cfg_error (output, 1 pulse).

Function
REQ-013 SHALL implement FSM states IDLE, LOAD_KERNEL, WAIT_READY, STREAM, ROW_END, DRAIN and DONE.
REQ-014 IDLE, start=1, all cfg values nonzero: latch cfg; pulse PE_Reset 1 cycle; clear row/col/in_ch/out_ch; go to LOAD_KERNEL.
REQ-015 IDLE, start=1, any cfg value zero: pulse cfg_error 1 cycle; remain in IDLE.
REQ-016 LOAD_KERNEL: hold kernel_req=1 until the cycle kernel_ack=1; next cycle pulse Load_kernel_reg 1 cycle with kernel_req=0; go to WAIT_READY.
REQ-017 WAIT_READY: go to STREAM on the first cycle PE_ready=1.
REQ-018 STREAM: col counts 0..cfg_width+1, i.e. a row is width+2 cycles, covering the padded 3x3 window.
REQ-019 STREAM: assert Stream_mid_row when row<height-1, else Stream_last_row; the two are never high together.
REQ-020 STREAM: assert Output_valid when col>=2.
REQ-021 STREAM with PE_ready=0: col holds; Stream_*/Output_valid deassert that cycle; resume on PE_ready=1.
REQ-022 STREAM at col=width+1 with PE_ready=1: go to ROW_END.
REQ-023 ROW_END: pulse Done_1row 1 cycle.
REQ-024 ROW_END, row<height-1: row++; go to WAIT_READY.
REQ-025 ROW_END, last row: row=0; if in_ch<in_ch_cfg-1 then in_ch++ and go to LOAD_KERNEL, else go to DRAIN.
REQ-026 last_channel SHALL be 1 from LOAD_KERNEL through ROW_END whenever in_ch=cfg_in_ch-1, including cfg_in_ch=1.
REQ-027 DRAIN: wait for PE_with_buffers_IDLE=1, then:
- out_ch<cfg_out_ch-1: out_ch++, in_ch=0, go to LOAD_KERNEL.
- otherwise: go to DONE.
REQ-028 DONE: pulse done 1 cycle; return to IDLE.
REQ-029 b_counter_output SHALL equal out_ch zero-extended or truncated to 8 bits; it changes only in DRAIN.
REQ-030 busy SHALL be 1 in every state except IDLE.
REQ-031 start while busy SHALL be ignored; cfg changes while busy SHALL have no effect.
REQ-032 Counters SHALL compare against latched cfg minus 1 with no wrap; width=1 gives 3 stream cycles and 1 valid.
REQ-033 kernel_ack outside LOAD_KERNEL SHALL be ignored.

Reset
REQ-034 Reset=1 at any clock edge, including mid-job: state=IDLE, all counters 0, every output 0 the next cycle.
REQ-035 Reset SHALL take priority over start and over every handshake input.

Verification
REQ-036 Directed scenarios:
- W=4,H=3,Cin=2,Cout=1, PE_ready=1, ack after 2 cycles -> 6 STREAM cycles/row; Output_valid 4/row (24 total); Done_1row 6; Load_kernel_reg 2; last_channel only on second pass; single done.
- W=2,H=2,Cin=1,Cout=3 -> b_counter_output 0,1,2 in turn; DRAIN held until PE_with_buffers_IDLE=1; last_channel always high while busy.
- PE_ready dropped 3 cycles at col=3 -> col frozen; Output_valid low exactly 3 cycles; row completes with 4 valids.
- start with cfg_height=0 -> cfg_error 1-cycle pulse; busy stays 0.
- Reset in STREAM, row 1 -> next cycle all outputs 0; new start restarts at row 0, out_ch 0 with a PE_Reset pulse.
- start held high during job and after done -> exactly one new job per IDLE start acceptance.
